// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
// Contents: loader FSM state enum, bytes per word, byte-address step per word.
// Optional feature macro used by importers: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs a big-endian byte stream into 32-bit words
// Ports:
//   clk        : rising-edge clock
//   clr        : synchronous clear of the partial word and byte count
//   byte_valid : a byte is transferred this cycle
//   byte_data  : the transferred byte
//   word_valid : combinational pulse on the cycle the 4th byte of a word is transferred
//   word_data  : assembled word, valid while word_valid is high (first byte in [31:24])
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // The completed word is presented in the same cycle as its last byte so the
    // consumer can register it and produce its strobe one cycle after acceptance.
    assign word_data = {shift_q, byte_data};

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clr) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_data};
            if (cnt_q == LAST_BYTE) begin
                word_valid = 1'b1;
                cnt_d      = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        shift_q <= shift_d;
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills instruction memory from a byte stream and holds the CPU until done
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : restart pulse, honoured only in DONE or ERR
//   in_valid, in_data, in_ready : byte stream handshake
//   wr_en, wr_addr, wr_data     : registered word-write port, byte addresses 0, 4, 8, ...
//   cpu_hold   : high in every state except DONE
//   done, error: success / rejection levels
// Stream: header word N, N data words, then a checksum word when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int Imem_width = 32,
    parameter int Imem_depth = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [Imem_width-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W = $clog2(Imem_depth) + 1;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        n_q, n_d;
    logic                    wr_en_q, wr_en_d;
    logic [31:0]             wr_addr_q, wr_addr_d;
    logic [Imem_width-1:0]   wr_data_q, wr_data_d;
    logic                    in_ready_q, in_ready_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]             xor_q, xor_d;
`endif

    logic        accept;
    logic        restart;
    logic        word_valid;
    logic [31:0] word;

    assign accept  = in_valid && in_ready_q;
    assign restart = start && ((state_q == ST_DONE) || (state_q == ST_ERR));

    // Reset and restart both discard any partial word held in the assembler.
    word_assembler u_asm (
        .clk        (clk),
        .clr        (rst || restart),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (word_valid) begin
                    idx_d = '0;
                    if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // An empty image still carries a checksum, which must be zero.
                        xor_d   = 32'd0;
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (word > 32'(Imem_depth)) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = word[IDX_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = 32'd0;
`endif
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'(idx_q) * 32'(ADDR_STEP);
                    wr_data_d = word;
                    idx_d     = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ word;
`endif
                    if (idx_q == n_q - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                // Writes already issued stay in memory; a bad checksum only blocks release.
                if (word_valid) begin
                    state_d = (word == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                    idx_d   = '0;
                    n_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = 32'd0;
`endif
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        // Status outputs are registered copies of the next state so they change
        // together with the state register.
        in_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CHK);
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HDR;
            idx_q      <= '0;
            n_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.Imem_width(32), .Imem_depth(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[8];
    logic [31:0] run_xor;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; every write strobe is checked against the scoreboard.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {63'd0, wr_en}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {32'd0, wr_addr}, {32'd0, e[63:32]});
                chk("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
            end
        end
    endtask

    task automatic status(input string tag, input logic rdy, input logic hold,
                          input logic dn, input logic er);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, hold});
        chk({tag, "_done"},     {63'd0, done},     {63'd0, dn});
        chk({tag, "_error"},    {63'd0, error},    {63'd0, er});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        logic acc;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    // Header, n data words from img[], and (checksum build) the XOR trailer
    // with 'flip' applied so a bad trailer can be requested.
    task automatic send_image(input int n, input int maxgap, input logic [31:0] flip);
        run_xor = 32'd0;
        send_word(32'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(i * 4), img[i]});
            run_xor = run_xor ^ img[i];
            send_word(img[i], maxgap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(run_xor ^ flip, maxgap);
`else
        if (flip != 32'd0) run_xor = run_xor ^ flip;
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        tick();
        tick();
        status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_wr_en",   {63'd0, wr_en},   64'd0);
        chk("reset_wr_addr", {32'd0, wr_addr}, 64'd0);
        chk("reset_wr_data", {32'd0, wr_data}, 64'd0);
        rst = 1'b0;
        tick();
        status("hdr", 1'b1, 1'b1, 1'b0, 1'b0);

        // Three-word program.
        img[0] = 32'h20080005; img[1] = 32'h2009000A; img[2] = 32'h01095020;
        send_image(3, 0, 32'd0);
        status("t1_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // rst and start together: reset wins.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        status("rst_start", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Oversized header is rejected.
        send_word(32'h00000065, 0);
        status("t2_err", 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        status("t2_err_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        status("t2_restart", 1'b1, 1'b1, 1'b0, 1'b0);

        // Empty image.
        send_image(0, 0, 32'd0);
        status("t3_empty", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();

        // Two words gap-free, then the same image with random gaps.
        img[0] = 32'hDEADBEEF; img[1] = 32'h00C0FFEE;
        send_image(2, 0, 32'd0);
        status("t4_nogap", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        send_image(2, 3, 32'd0);
        status("t4_gap", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
        pulse_start();

        // start during LOAD is ignored.
        send_word(32'd2, 0);
        exp_q.push_back({32'd0, img[0]});
        send_word(img[0], 0);
        pulse_start();
        status("t4_start_ign", 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({32'd4, img[1]});
        send_word(img[1], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(img[0] ^ img[1], 0);
`endif
        status("t4_ign_done", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();

        // Maximum header (N == depth) is accepted; reset mid second word aborts.
        send_word(32'd100, 0);
        status("t5_max_hdr", 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({32'd0, 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        chk("t5_rst_wr_en", {63'd0, wr_en}, 64'd0);
        status("t5_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        img[0] = 32'h01095020;
        send_image(1, 0, 32'd0);
        status("t5_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum: matching trailer, then a zero trailer that must be rejected.
        pulse_start();
        img[0] = 32'h12345678; img[1] = 32'h0000FFFF;
        send_image(2, 0, 32'd0);
        chk("ck_xor_model", {32'd0, run_xor}, {32'd0, 32'h1234A987});
        status("ck_good", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        send_image(2, 0, 32'h1234A987);
        status("ck_bad", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        status("ck_restart", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        tick(); tick();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential writer that fills the instruction memory from an external byte stream before the processor runs. It accepts bytes over a valid/ready handshake, assembles big-endian 32-bit words, and emits one word-write per assembled word at byte addresses 0, 4, 8, … matching the PC-based addressing (`PC>>2`) of the read side. It holds the CPU in reset until the image is fully loaded.

## Interface
- `Imem_width`, default 32: instruction word width; fixed at 32 (4 bytes per word).
- `Imem_depth`, default 100: number of words in instruction memory; maximum accepted image length.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: single-cycle pulse; restarts loading from DONE or ERR; ignored in other states.
- `in_valid` input 1: byte present on `in_data`.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: one-cycle write strobe to instruction memory.
- `wr_addr` output 32: byte address of the write, always a multiple of 4.
- `wr_data` output 32: instruction word to write.
- `cpu_hold` output 1: processor must be held in reset while high.
- `done` output 1: image loaded successfully (level).
- `error` output 1: image rejected (level).

## Operation
- Byte transfer occurs only on a cycle with `in_valid && in_ready`; no other condition changes the byte counter.
- Words are big-endian: the first byte of a word is bits [31:24].
- Stream format: header word N (word count), then N data words, then (macro-enabled only) one checksum word.
- States: HDR (collect N), LOAD (collect data words), CHK (collect checksum, macro only), DONE, ERR.
- HDR: on the 4th byte, if N == 0 go to DONE; if N > `Imem_depth` go to ERR; otherwise latch N, clear word index, go to LOAD.
- LOAD: on each 4th byte, write the word at `wr_addr = 4*idx`, then increment idx. After word N-1, go to CHK (macro) or DONE.
- DONE/ERR: `in_ready` = 0; stay until `start`, which goes to HDR with all counters cleared and `done`/`error` cleared.
- `start` in HDR/LOAD/CHK is ignored.
- `cpu_hold` = 1 in every state except DONE.
- Word index width is `$clog2(Imem_depth)+1`; `wr_addr` is the zero-extended index shifted left by 2. No wrap-around is possible because N ≤ `Imem_depth`.

## Timing
- Reset values: `in_ready`=0 in the reset cycle, then 1 (state HDR); `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0.
- `in_ready` is a registered function of state: 1 in HDR/LOAD/CHK. Throughput is one byte per cycle.
- `wr_en`, `wr_addr`, and `wr_data` are registered. `wr_en` is high exactly one cycle, the cycle after the 4th byte of a data word is accepted.
- The state transition on the last byte takes effect next cycle. `done` and `cpu_hold`=0 appear together one cycle after the final accepting byte, coinciding with the last `wr_en` when there is no checksum.
- `rst` mid-load aborts immediately: partial word discarded, `wr_en` forced 0 that cycle, state HDR, `cpu_hold`=1.
- If `rst` and `start` are high together, `rst` wins.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR of all data words is kept.
  - After word N-1, the FSM enters CHK and collects one more word.
  - Equal to the XOR → DONE; mismatch → ERR.
  - Memory writes are not retracted on a mismatch; `cpu_hold` stays 1 in ERR.
  - With N == 0, the checksum word is still required and must equal 0.
- Undefined: no CHK state and no XOR register; LOAD goes directly to DONE.

## Structure
- Package `imem_loader_pkg`: state enum (HDR, LOAD, CHK, DONE, ERR), `BYTES_PER_WORD`=4, `ADDR_STEP`=4.
- Sub-module `word_assembler`:
  - Shifts in bytes and counts 0..3.
  - Outputs `word_valid` pulse plus the 32-bit word.
  - Has a synchronous clear used by `rst`/`start`.
- Top level holds the FSM, word index, N register, XOR register, and output registers.

## Test plan
- Stream header 00000003, then 20080005, 2009000A, 01095020 → `wr_en` pulses at addresses 0, 4, 8 with those words; `done`=1, `cpu_hold`=0 one cycle after the last byte.
- Header 00000065 (101 > 100) → `error`=1 after the 4th byte, no `wr_en`, `in_ready`=0, `cpu_hold`=1.
- Header 00000000 (checksum disabled) → `done`=1 one cycle after header, no writes.
- Randomized `in_valid` gaps with a 2-word image → identical writes and addresses as the gap-free run.
- `rst` after 2 bytes of the second data word, then a full 1-word image → only the new image's word written at address 0.
- Checksum enabled: words 12345678, 0000FFFF, then trailer 1234A987 → DONE; trailer 00000000 → ERR. `start` from ERR → HDR with `in_ready`=1.
